// File: rtl/fifo_ram_16x8.sv
// fifo_ram_16x8: synchronous circular FIFO with registered read data.
// Single clock, asynchronous active-low reset. The storage array is not
// reset; after reset or clear it is simply unreadable until rewritten because
// contagem is 0. Overflow/underflow are sticky until limpar or reset.
module fifo_ram_16x8 #(
    parameter int LARGURA       = 8,
    parameter int ENDERECO_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     escrever,
    input  logic [LARGURA-1:0]       dado_in,
    input  logic                     ler,
    input  logic                     limpar,
    output logic [LARGURA-1:0]       dado_out,
    output logic                     valido_out,
    output logic                     cheio,
    output logic                     vazio,
    output logic [ENDERECO_BITS:0]   contagem,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int DEPTH = 1 << ENDERECO_BITS;
    localparam logic [ENDERECO_BITS-1:0] PTR_ONE  = 1;
    localparam logic [ENDERECO_BITS:0]   CNT_ONE  = 1;
    localparam logic [ENDERECO_BITS:0]   CNT_FULL = (ENDERECO_BITS+1)'(DEPTH);

    logic [LARGURA-1:0]       mem [DEPTH];
    logic [ENDERECO_BITS-1:0] wr_ptr;
    logic [ENDERECO_BITS-1:0] rd_ptr;
    logic                     rd_ok;
    logic                     wr_ok;

    // Flags come straight from the occupancy count.
    assign cheio = (contagem == CNT_FULL);
    assign vazio = (contagem == '0);

    // A read needs data; a write needs room, or a simultaneous pop freeing a slot.
    // No fall-through: on empty a concurrent write does not satisfy the read.
    assign rd_ok = ler && !vazio;
    assign wr_ok = escrever && (!cheio || rd_ok);

    // Storage write; gated by reset so a request during reset is discarded.
    always_ff @(posedge clk) begin
        if (reset && !limpar && wr_ok)
            mem[wr_ptr] <= dado_in;
    end

    // Pointers, count, read data, valid pulse and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            contagem   <= '0;
            dado_out   <= '0;
            valido_out <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (limpar) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            contagem   <= '0;
            dado_out   <= '0;
            valido_out <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            valido_out <= rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) begin
                dado_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   contagem <= contagem + CNT_ONE;
                2'b01:   contagem <= contagem - CNT_ONE;
                default: contagem <= contagem;
            endcase
            if (escrever && !wr_ok)
                overflow <= 1'b1;
            if (ler && !rd_ok)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ram_16x8.sv
// tb_fifo_ram_16x8: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the FIFO.
module tb_fifo_ram_16x8;
    logic       clk = 1'b0;
    logic       reset;
    logic       escrever;
    logic [7:0] dado_in;
    logic       ler;
    logic       limpar;
    logic [7:0] dado_out;
    logic       valido_out;
    logic       cheio;
    logic       vazio;
    logic [4:0] contagem;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_vld;
    logic       m_ovf;
    logic       m_unf;

    fifo_ram_16x8 #(.LARGURA(8), .ENDERECO_BITS(4)) dut (
        .clk(clk), .reset(reset), .escrever(escrever), .dado_in(dado_in),
        .ler(ler), .limpar(limpar), .dado_out(dado_out), .valido_out(valido_out),
        .cheio(cheio), .vazio(vazio), .contagem(contagem),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dado_out"},   32'(dado_out),   32'(m_dout));
        chk({tag, ".valido_out"}, 32'(valido_out), 32'(m_vld));
        chk({tag, ".contagem"},   32'(contagem),   32'(q.size()));
        chk({tag, ".cheio"},      32'(cheio),      32'(q.size() == 16));
        chk({tag, ".vazio"},      32'(vazio),      32'(q.size() == 0));
        chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".underflow"},  32'(underflow),  32'(m_unf));
    endtask

    // Apply one cycle of requests, advance the model, clock the DUT, compare.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input string tag);
        bit rd, wr;
        escrever = w; dado_in = d; ler = r; limpar = c;
        if (c) begin
            model_reset();
        end else begin
            rd = r && (q.size() != 0);
            wr = w && ((q.size() < 16) || rd);
            if (r && !rd) m_unf = 1'b1;
            if (w && !wr) m_ovf = 1'b1;
            m_vld = rd;
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(d);
        end
        @(posedge clk);
        #1;
        escrever = 1'b0; ler = 1'b0; limpar = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int pw, pr;
        reset = 1'b0; escrever = 1'b0; ler = 1'b0; limpar = 1'b0; dado_in = 8'h00;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // three writes, three reads
        step(1, 8'hAA, 0, 0, "w1");
        step(1, 8'h55, 0, 0, "w2");
        step(1, 8'h0F, 0, 0, "w3");
        step(0, 8'h00, 1, 0, "r1"); chk("r1.val", 32'(dado_out), 32'hAA);
        step(0, 8'h00, 1, 0, "r2"); chk("r2.val", 32'(dado_out), 32'h55);
        step(0, 8'h00, 1, 0, "r3"); chk("r3.val", 32'(dado_out), 32'h0F);
        chk("r3.vazio", 32'(vazio), 32'd1);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "fill");
        chk("fill.cheio", 32'(cheio), 32'd1);
        step(1, 8'hFF, 0, 0, "ovf");
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.cnt", 32'(contagem), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, "drain");
            chk("drain.order", 32'(dado_out), 32'(i));
        end
        step(0, 8'h00, 0, 1, "clr1");

        // simultaneous write/read on full
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "fill2");
        step(1, 8'h77, 1, 0, "full_wr");
        chk("full_wr.out", 32'(dado_out), 32'h00);
        chk("full_wr.cnt", 32'(contagem), 32'd16);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "drain2");
        chk("drain2.last", 32'(dado_out), 32'h77);

        // underflow, then simultaneous write/read on empty
        step(0, 8'h00, 1, 0, "unf");
        chk("unf.flag", 32'(underflow), 32'd1);
        chk("unf.hold", 32'(dado_out), 32'h77);
        step(1, 8'h33, 1, 0, "empty_wr");
        chk("empty_wr.cnt", 32'(contagem), 32'd1);
        step(0, 8'h00, 1, 0, "empty_rd");
        chk("empty_rd.val", 32'(dado_out), 32'h33);

        // clear with flags set
        step(1, 8'h01, 0, 0, "pre_clr");
        step(1, 8'h02, 1, 1, "clr2");
        chk("clr2.flags", 32'({overflow, underflow}), 32'd0);

        // 20 words with interleaved reads, pointers wrap
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h40 + i), 0, 0, "wrap_w");
            if (i % 2 == 1) step(0, 8'h00, 1, 0, "wrap_r");
        end
        while (q.size() != 0) step(0, 8'h00, 1, 0, "wrap_drain");
        chk("wrap.last", 32'(dado_out), 32'h53);
        chk("wrap.flags", 32'({overflow, underflow}), 32'd0);

        // asynchronous reset between edges, request held during reset
        step(1, 8'h11, 0, 0, "pre_rst");
        step(1, 8'h22, 1, 0, "pre_rst2");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        escrever = 1'b1; ler = 1'b1; dado_in = 8'h99;
        @(posedge clk);
        #1;
        escrever = 1'b0; ler = 1'b0;
        check_all("rst_hold");
        reset = 1'b1;
        step(1, 8'h5A, 0, 0, "post_rst");
        step(0, 8'h00, 1, 0, "post_rst_rd");
        chk("post_rst.val", 32'(dado_out), 32'h5A);

        // randomized traffic with shifting write/read bias
        for (int i = 0; i < 900; i++) begin
            case ((i / 60) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 55; pr = 55; end
            endcase
            step(1'($urandom_range(0, 99) < pw), 8'($urandom),
                 1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 79) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
